// File: rtl/crc_pkg.sv
// crc_pkg: shared types, default constants and the bit-serial CRC update
// used by the streaming encoder (crc_stream_enc) and the checker.
//
// Contents:
//   state_t    - encoder frame state (IDLE, BODY, TAIL)
//   DEF_DW     - default data beat width
//   DEF_CW     - default CRC width
//   DEF_POLY   - default generator polynomial, x^6 + x + 1 without x^CW
//   crc_next() - MSB-first CRC step over a whole data beat
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    TAIL
  } state_t;

  localparam int DEF_DW = 32;
  localparam int DEF_CW = 6;
  localparam logic [DEF_CW-1:0] DEF_POLY = 6'h03;

  // The function works on fixed maximum-width containers. Callers zero-extend
  // their operands and pass the real widths in cw/dw, so one function serves
  // every parameterisation of the encoder and the checker.
  localparam int CRC_MAX_W  = 32;
  localparam int DATA_MAX_W = 256;

  // Per data bit, MSB first:
  //   fb  = crc[cw-1] ^ d
  //   crc = {crc[cw-2:0], 0} ^ (fb ? poly : 0)
  // The data is left-aligned first so the next bit is always the container
  // MSB. The CRC is kept masked to cw bits, so the shifted-out MSB never leaks
  // into the upper part of the container. No reflection and no final XOR.
  function automatic logic [CRC_MAX_W-1:0] crc_next(
    input logic [CRC_MAX_W-1:0]  crc,
    input logic [DATA_MAX_W-1:0] data,
    input logic [CRC_MAX_W-1:0]  poly,
    input int                    cw,
    input int                    dw
  );
    logic [CRC_MAX_W-1:0]  c;
    logic [CRC_MAX_W-1:0]  cw_mask;
    logic [CRC_MAX_W-1:0]  msb_mask;
    logic [DATA_MAX_W-1:0] d;
    logic                  fb;
    cw_mask  = ~({CRC_MAX_W{1'b1}} << cw);
    msb_mask = {{(CRC_MAX_W-1){1'b0}}, 1'b1} << (cw - 1);
    c        = crc & cw_mask;
    d        = data << (DATA_MAX_W - dw);
    for (int i = 0; i < DATA_MAX_W; i++) begin
      if (i < dw) begin
        fb = (|(c & msb_mask)) ^ d[DATA_MAX_W-1];
        c  = ((c << 1) ^ (fb ? (poly & cw_mask) : '0)) & cw_mask;
        d  = d << 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_comb_upd.sv
// crc_comb_upd: combinational single-cycle CRC step over one DW-bit beat.
// The same step is used by the streaming encoder and the checker.
//
// Parameters:
//   DW   - data beat width
//   CW   - CRC width
//   POLY - generator polynomial without the implicit x^CW term
//
// Ports:
//   crc_in  [CW-1:0] - CRC value before this beat
//   data    [DW-1:0] - beat; bit DW-1 enters the CRC first
//   crc_out [CW-1:0] - CRC value after the whole beat
module crc_comb_upd
  import crc_pkg::*;
#(
  parameter int             DW   = DEF_DW,
  parameter int             CW   = DEF_CW,
  parameter logic [CW-1:0]  POLY = DEF_POLY
) (
  input  logic [CW-1:0] crc_in,
  input  logic [DW-1:0] data,
  output logic [CW-1:0] crc_out
);

  // The loop inside crc_next is fully unrolled by synthesis because CW and DW
  // are elaboration-time constants.
  assign crc_out = CW'(crc_next(CRC_MAX_W'(crc_in), DATA_MAX_W'(data),
                                CRC_MAX_W'(POLY), CW, DW));

endmodule

// File: rtl/crc_stream_enc.sv
// crc_stream_enc: streaming CRC encoder. Each data beat passes through a
// single output register slot. After the last data beat of a frame, one CRC
// beat {zeros, crc} is appended.
//
// Optional build macro: CRC_FRAME_CNT_EN adds o_frame_cnt, a wrapping 16-bit
// count of completed CRC-beat handshakes.
//
// Parameters:
//   DW   - data beat width (>= CW)
//   CW   - CRC width
//   POLY - generator polynomial without the implicit x^CW term
//   INIT - CRC value loaded at start of frame
//
// Ports:
//   clk, reset_n          - clock; asynchronous active-low reset
//   i_valid / i_ready     - input handshake
//   i_sof / i_last        - first / last beat of frame
//   i_data [DW-1:0]       - payload beat
//   o_valid / o_ready     - output handshake
//   o_data [DW-1:0]       - payload beat or CRC beat
//   o_is_crc, o_last      - both set only on the CRC beat
//   o_sof_err             - one-cycle pulse when i_sof arrives inside an open frame
//   o_frame_cnt [15:0]    - completed frame count (CRC_FRAME_CNT_EN only)
module crc_stream_enc
  import crc_pkg::*;
#(
  parameter int             DW   = DEF_DW,
  parameter int             CW   = DEF_CW,
  parameter logic [CW-1:0]  POLY = DEF_POLY,
  parameter logic [CW-1:0]  INIT = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic          i_sof,
  input  logic          i_last,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic          o_is_crc,
  output logic          o_last,
  output logic          o_sof_err
`ifdef CRC_FRAME_CNT_EN
  ,
  output logic [15:0]   o_frame_cnt
`endif
);

  state_t        state;
  logic [CW-1:0] crc;
  logic [CW-1:0] crc_base;
  logic [CW-1:0] crc_upd;
  logic          slot_free;
  logic          accept;

  // The output slot can take a new beat when it is empty or is being drained
  // in this cycle. While in TAIL, the slot is reserved for the CRC beat.
  assign slot_free = !o_valid || o_ready;
  assign i_ready   = slot_free && (state != TAIL);
  assign accept    = i_valid && i_ready;

  // Continue the running CRC only inside an open frame. Any beat in IDLE,
  // and an i_sof beat inside BODY (which abandons the open frame), restarts
  // the CRC from INIT.
  assign crc_base = (state == BODY && !i_sof) ? crc : INIT;

  crc_comb_upd #(
    .DW   (DW),
    .CW   (CW),
    .POLY (POLY)
  ) u_upd (
    .crc_in  (crc_base),
    .data    (i_data),
    .crc_out (crc_upd)
  );

  // Frame FSM, CRC register and output slot, all updated together. If the
  // slot drains and nothing new is loaded, o_valid drops; o_data, o_is_crc
  // and o_last keep their old values until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      crc       <= INIT;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_is_crc  <= 1'b0;
      o_last    <= 1'b0;
      o_sof_err <= 1'b0;
    end else begin
      o_sof_err <= 1'b0;
      if (slot_free) begin
        o_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            o_valid  <= 1'b1;
            o_data   <= i_data;
            o_is_crc <= 1'b0;
            o_last   <= 1'b0;
            crc      <= crc_upd;
            state    <= i_last ? TAIL : BODY;
          end
        end
        BODY: begin
          if (accept) begin
            o_valid  <= 1'b1;
            o_data   <= i_data;
            o_is_crc <= 1'b0;
            o_last   <= 1'b0;
            crc      <= crc_upd;
            if (i_sof) begin
              o_sof_err <= 1'b1;
            end
            state <= i_last ? TAIL : BODY;
          end
        end
        TAIL: begin
          if (slot_free) begin
            o_valid  <= 1'b1;
            o_data   <= DW'(crc);
            o_is_crc <= 1'b1;
            o_last   <= 1'b1;
            crc      <= INIT;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CRC_FRAME_CNT_EN
  // Counts only CRC beats that complete their handshake. Abandoned frames
  // never produce a CRC beat, so they are never counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_frame_cnt <= '0;
    end else if (o_valid && o_ready && o_is_crc) begin
      o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crc_stream_enc.sv
// tb_crc_stream_enc: scoreboard testbench for crc_stream_enc with default
// parameters (DW=32, CW=6, POLY=x^6+x+1, INIT=0). Expected output beats are
// queued when an input beat is accepted. A negedge monitor pops each entry
// when the matching output handshake occurs and compares it.
module tb_crc_stream_enc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic        i_sof = 1'b0;
  logic        i_last = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_data;
  logic        o_is_crc;
  logic        o_last;
  logic        o_sof_err;
`ifdef CRC_FRAME_CNT_EN
  logic [15:0] o_frame_cnt;
`endif

  crc_stream_enc dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_sof     (i_sof),
    .i_last    (i_last),
    .i_data    (i_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_is_crc  (o_is_crc),
    .o_last    (o_last),
    .o_sof_err (o_sof_err)
`ifdef CRC_FRAME_CNT_EN
    ,
    .o_frame_cnt (o_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        is_crc;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [5:0]  model_crc = '0;
  logic        model_open = 1'b0;
  logic [5:0]  last_crc = '0;
  logic        rand_ready_en = 1'b0;

  // Reference CRC: remainder of (crc * x^32 + data * x^6) mod (x^6 + x + 1),
  // computed by polynomial long division on a 38-bit value.
  function automatic logic [5:0] model_step(input logic [5:0] crc, input logic [31:0] data);
    logic [37:0] v;
    v = {crc, 32'b0} ^ {data, 6'b0};
    for (int k = 37; k >= 6; k--) begin
      if (v[k]) v = v ^ (38'h43 << (k - 6));
    end
    return v[5:0];
  endfunction

  // Scoreboard monitor: a beat transfers at the next posedge when valid and
  // ready are both high at this negedge.
  always @(negedge clk) begin
    if (reset_n && o_valid && o_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_beat got data=%h is_crc=%b expected no beat", o_data, o_is_crc);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_data !== mon_e.data || o_is_crc !== mon_e.is_crc || o_last !== mon_e.is_crc) begin
          failures++;
          $display("[TB] FAIL out_beat got data=%h is_crc=%b last=%b expected data=%h is_crc=%b last=%b",
                   o_data, o_is_crc, o_last, mon_e.data, mon_e.is_crc, mon_e.is_crc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready_en) o_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_beat(input logic [31:0] data, input logic sof, input logic last);
    logic accepted;
    int   waited;
    accepted = 1'b0;
    waited   = 0;
    i_valid = 1'b1;
    i_data  = data;
    i_sof   = sof;
    i_last  = last;
    while (!accepted && waited <= 200) begin
      @(negedge clk);
      if (i_ready) begin
        accepted  = 1'b1;
        model_crc = model_step((model_open && !sof) ? model_crc : 6'h00, data);
        exp_q.push_back('{data: data, is_crc: 1'b0});
        if (last) begin
          exp_q.push_back('{data: {26'b0, model_crc}, is_crc: 1'b1});
          last_crc   = model_crc;
          model_open = 1'b0;
        end else begin
          model_open = 1'b1;
        end
      end else begin
        waited++;
      end
      tick();
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout got i_ready=%b expected acceptance within 200 cycles", i_ready);
    end
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL drain got %0d pending beats expected 0", exp_q.size());
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    exp_q.delete();
    model_open = 1'b0;
    model_crc  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_o_valid got %b expected 0", o_valid); end
    checks++;
    if (o_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_o_data got %h expected 0", o_data); end
    checks++;
    if (o_is_crc !== 1'b0 || o_last !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_flags got is_crc=%b last=%b expected 0 0", o_is_crc, o_last);
    end
    checks++;
    if (o_sof_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_sof_err got %b expected 0", o_sof_err); end
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_i_ready got %b expected 1", i_ready); end
`ifdef CRC_FRAME_CNT_EN
    checks++;
    if (o_frame_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_frame_cnt got %0d expected 0", o_frame_cnt); end
`endif
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    o_ready = 1'b1;
    drive_beat(32'h00000001, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h00000001 || o_is_crc !== 1'b0) begin
      failures++;
      $display("[TB] FAIL latency_data got valid=%b data=%h is_crc=%b expected 1 00000001 0", o_valid, o_data, o_is_crc);
    end
    checks++;
    if (i_ready !== 1'b0) begin failures++; $display("[TB] FAIL tail_i_ready got %b expected 0", i_ready); end
    tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 32'h00000003 || o_last !== 1'b1 || o_is_crc !== 1'b1) begin
      failures++;
      $display("[TB] FAIL latency_crc got valid=%b data=%h last=%b expected 1 00000003 1", o_valid, o_data, o_last);
    end
    checks++;
    if (i_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_tail_i_ready got %b expected 1", i_ready); end
    tick();
    drain();
  endtask

  task automatic test_single_values();
    logic [31:0] din [2];
    logic [5:0]  want [2];
    din[0] = 32'h00000002; want[0] = 6'h06;
    din[1] = 32'h00000000; want[1] = 6'h00;
    o_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      drive_beat(din[t], 1'b1, 1'b1);
      checks++;
      if (last_crc !== want[t]) begin
        failures++;
        $display("[TB] FAIL model_crc_%0d got %h expected %h", t, last_crc, want[t]);
      end
      drain();
    end
  endtask

  task automatic test_two_beat();
    int lows;
    lows = 0;
    o_ready = 1'b1;
    drive_beat(32'h00000000, 1'b1, 1'b0);
    drive_beat(32'h00000001, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (!i_ready) lows++;
      if (c == 1) begin
        checks++;
        if (o_data !== 32'h00000003 || o_is_crc !== 1'b1) begin
          failures++;
          $display("[TB] FAIL two_beat_crc got data=%h is_crc=%b expected 00000003 1", o_data, o_is_crc);
        end
      end
      tick();
    end
    checks++;
    if (lows !== 1) begin failures++; $display("[TB] FAIL two_beat_bubble got %0d low cycles expected 1", lows); end
    drain();
  endtask

  task automatic test_backpressure();
    o_ready = 1'b1;
    drive_beat(32'hA5A50001, 1'b1, 1'b0);
    drive_beat(32'h12345678, 1'b0, 1'b1);
    tick();
    o_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_is_crc !== 1'b1 || o_last !== 1'b1 || o_data !== {26'b0, last_crc} || i_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL hold_%0d got valid=%b is_crc=%b data=%h i_ready=%b expected 1 1 %h 0",
                 c, o_valid, o_is_crc, o_data, i_ready, {26'b0, last_crc});
      end
      tick();
    end
    o_ready = 1'b1;
    drain();
    tick();
    tick();
  endtask

  task automatic test_sof_err();
    o_ready = 1'b1;
    drive_beat(32'h00000011, 1'b1, 1'b0);
    drive_beat(32'h00000022, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (o_sof_err !== 1'b0) begin failures++; $display("[TB] FAIL sof_err_idle got %b expected 0", o_sof_err); end
    tick();
    drive_beat(32'h00000033, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (o_sof_err !== 1'b1) begin failures++; $display("[TB] FAIL sof_err_pulse got %b expected 1", o_sof_err); end
    tick();
    @(negedge clk);
    checks++;
    if (o_sof_err !== 1'b0) begin failures++; $display("[TB] FAIL sof_err_width got %b expected 0", o_sof_err); end
    tick();
    drive_beat(32'h00000044, 1'b0, 1'b1);
    checks++;
    if (last_crc !== model_step(model_step(6'h00, 32'h00000033), 32'h00000044)) begin
      failures++;
      $display("[TB] FAIL restart_model got %h expected restart from INIT", last_crc);
    end
    drain();
  endtask

  task automatic test_random();
    int len;
    rand_ready_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        drive_beat($urandom, (b == 0), (b == len - 1));
      end
    end
    rand_ready_en = 1'b0;
    o_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_in_tail();
    o_ready = 1'b1;
    drive_beat(32'h00000007, 1'b1, 1'b1);
    reset_n = 1'b0;
    exp_q.delete();
    model_open = 1'b0;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_is_crc !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_tail got valid=%b is_crc=%b expected 0 0", o_valid, o_is_crc);
    end
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_tail got valid=%b expected 0", o_valid); end
    tick();
  endtask

`ifdef CRC_FRAME_CNT_EN
  task automatic test_frame_cnt();
    apply_reset();
    o_ready = 1'b1;
    drive_beat(32'h00000001, 1'b1, 1'b0);
    drive_beat(32'h00000002, 1'b1, 1'b1);
    drive_beat(32'h00000003, 1'b1, 1'b1);
    drive_beat(32'h00000004, 1'b1, 1'b0);
    drive_beat(32'h00000005, 1'b0, 1'b1);
    drain();
    tick();
    @(negedge clk);
    checks++;
    if (o_frame_cnt !== 16'd3) begin failures++; $display("[TB] FAIL frame_cnt got %0d expected 3", o_frame_cnt); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_single_values();
    test_two_beat();
    test_backpressure();
    test_sof_err();
    test_random();
    test_reset_in_tail();
`ifdef CRC_FRAME_CNT_EN
    test_frame_cnt();
`endif
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
